// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-port FIFO arbiter.
// FSM encoding and push/pop opcode values used by fifo_arb and its bench.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   // A request is rejected when it would over- or under-run the FIFO.
   function automatic logic is_reject(input logic op, input logic full, input logic empty);
      return (op == OP_POP) ? empty : full;
   endfunction

endpackage

// File: rtl/fifo_arb_rr_arb2.sv
// Two-way round-robin grant. The last-grant register starts at port 1
// so that port 0 wins the first tie.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   input  logic       i_upd,
   output logic       o_gnt,
   output logic       o_any
);

   logic last;

   always_comb begin
      o_any = |i_req;
      if (&i_req) o_gnt = ~last;
      else        o_gnt = ~i_req[0];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)              last <= 1'b1;
      else if (i_en && i_upd) last <= o_gnt;
   end

endmodule

// File: rtl/fifo_arb.sv
// Shares one FIFO between two level-held requesters: round-robin grant,
// overflow/underflow rejection and the FIFO strobe/acknowledge handshake.
module fifo_arb
   import fifo_arb_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 256,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_req0,
   input  logic             i_req1,
   input  logic             i_op0,
   input  logic             i_op1,
   input  logic [WIDTH-1:0] i_wdata0,
   input  logic [WIDTH-1:0] i_wdata1,
   output logic             o_ack0,
   output logic             o_ack1,
   output logic             o_err0,
   output logic             o_err1,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_fifo_en,
   output logic             o_fifo_set,
   output logic             o_fifo_get,
   output logic [WIDTH-1:0] o_fifo_data,
   input  logic             i_fifo_set,
   input  logic             i_fifo_get,
   input  logic [WIDTH-1:0] i_fifo_data
);

   state_t                 state, state_nxt;
   logic [1:0]             req, op;
   logic [1:0][WIDTH-1:0]  wdata;
   logic                   gnt, any_req, upd;
   logic                   sel_op, sel_rej, xfer_done;
   logic                   gnt_q, op_q, err_q;

   assign req   = {i_req1, i_req0};
   assign op    = {i_op1, i_op0};
   assign wdata = {i_wdata1, i_wdata0};

   assign o_fifo_en = i_en;
   assign o_full    = (o_count == CW'(DEPTH));
   assign o_empty   = (o_count == '0);

   assign sel_op    = op[gnt];
   assign sel_rej   = is_reject(sel_op, o_full, o_empty);
   assign xfer_done = (op_q == OP_POP) ? i_fifo_get : i_fifo_set;
   assign upd       = (state == ST_IDLE) && any_req;

   rr_arb2 u_arb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (i_en),
      .i_req (req),
      .i_upd (upd),
      .o_gnt (gnt),
      .o_any (any_req)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     state <= ST_IDLE;
      else if (i_en) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (any_req) state_nxt = sel_rej ? ST_RESP : ST_XFER;
         ST_XFER: if (xfer_done) state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ack0 = (state == ST_RESP) && !gnt_q;
      o_ack1 = (state == ST_RESP) &&  gnt_q;
      o_err0 = o_ack0 && err_q;
      o_err1 = o_ack1 && err_q;
   end

   // The strobe stays up until the FIFO acknowledges; the FIFO ignores
   // the second strobe cycle, so it never double-writes or double-reads.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         gnt_q       <= 1'b0;
         op_q        <= OP_PUSH;
         err_q       <= 1'b0;
         o_fifo_set  <= 1'b0;
         o_fifo_get  <= 1'b0;
         o_fifo_data <= '0;
         o_rdata     <= '0;
         o_count     <= '0;
      end else if (i_en) begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  gnt_q <= gnt;
                  op_q  <= sel_op;
                  err_q <= sel_rej;
                  if (!sel_rej) begin
                     if (sel_op == OP_PUSH) begin
                        o_fifo_set  <= 1'b1;
                        o_fifo_data <= wdata[gnt];
                     end else begin
                        o_fifo_get  <= 1'b1;
                     end
                  end
               end
            end
            ST_XFER: begin
               if (xfer_done) begin
                  o_fifo_set <= 1'b0;
                  o_fifo_get <= 1'b0;
                  if (op_q == OP_POP) begin
                     o_rdata <= i_fifo_data;
                     o_count <= o_count - CW'(1);
                  end else begin
                     o_count <= o_count + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_arb.sv
// Random two-port traffic against a queue-based model of fifo_arb, with a
// behavioural FIFO on the strobe/ack side, random enable stalls and resets.
module tb_fifo_arb;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]       rq, ro;
   logic [WIDTH-1:0] rw [2];

   logic             ack0, ack1, err0, err1, full, empty;
   logic             fifo_en, fifo_set, fifo_get;
   logic [WIDTH-1:0] rdata, fifo_data;
   logic [CW-1:0]    count;

   // behavioural FIFO: one-cycle ack, ignores a strobe while its ack is high
   logic             f_set, f_get;
   logic [WIDTH-1:0] f_dout;
   logic [WIDTH-1:0] mem [DEPTH];
   int               wp, rp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         f_set <= 1'b0; f_get <= 1'b0; f_dout <= '0; wp <= 0; rp <= 0;
      end else if (fifo_en) begin
         f_set <= fifo_set & ~f_set;
         f_get <= fifo_get & ~f_get;
         if (fifo_set && !f_set) begin
            mem[wp] <= fifo_data;
            wp <= (wp + 1) % DEPTH;
         end
         if (fifo_get && !f_get) begin
            f_dout <= mem[rp];
            rp <= (rp + 1) % DEPTH;
         end
      end
   end

   fifo_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en),
      .i_req0(rq[0]), .i_req1(rq[1]), .i_op0(ro[0]), .i_op1(ro[1]),
      .i_wdata0(rw[0]), .i_wdata1(rw[1]),
      .o_ack0(ack0), .o_ack1(ack1), .o_err0(err0), .o_err1(err1),
      .o_rdata(rdata), .o_count(count), .o_full(full), .o_empty(empty),
      .o_fifo_en(fifo_en), .o_fifo_set(fifo_set), .o_fifo_get(fifo_get),
      .o_fifo_data(fifo_data),
      .i_fifo_set(f_set), .i_fifo_get(f_get), .i_fifo_data(f_dout)
   );

   int errors = 0;
   int checks = 0;

   // model state, time measured in enabled clock edges
   int               k, next_samp, s_edge, ack_edge, last;
   logic             cur_port, cur_op, cur_rej, en_s;
   logic [WIDTH-1:0] cur_data, exp_rdata;
   logic [WIDTH-1:0] q [$];
   int               n_ack, n_rst, pop_pct, en_low;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_err", {err1, err0}, 0);
      check("rst_strobe", {fifo_get, fifo_set}, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_rdata", rdata, 0);
      check("rst_fdata", fifo_data, 0);
   endtask

   task automatic model_step();
      int p;
      if (k == next_samp) begin
         if (rq != 2'b00) begin
            if (rq == 2'b11) p = (last == 0) ? 1 : 0;
            else             p = rq[1] ? 1 : 0;
            last     = p;
            cur_port = p[0];
            cur_op   = ro[p];
            cur_data = rw[p];
            cur_rej  = cur_op ? (q.size() == 0) : (q.size() == DEPTH);
            s_edge   = k;
            ack_edge = cur_rej ? k : k + 2;
            next_samp = ack_edge + 2;
         end else begin
            next_samp = k + 1;
         end
      end
      if (k == ack_edge) begin
         n_ack++;
         if (!cur_rej) begin
            if (cur_op == 1'b0) q.push_back(cur_data);
            else                exp_rdata = q.pop_front();
         end
      end
   endtask

   task automatic compare();
      logic a, xf;
      a  = (k == ack_edge);
      xf = (s_edge > 0) && !cur_rej && (k == s_edge || k == s_edge + 1);
      check("ack0", ack0, a && !cur_port);
      check("ack1", ack1, a && cur_port);
      check("err0", err0, a && !cur_port && cur_rej);
      check("err1", err1, a && cur_port && cur_rej);
      check("fifo_set", fifo_set, xf && !cur_op);
      check("fifo_get", fifo_get, xf && cur_op);
      if (xf && !cur_op) check("fifo_data", fifo_data, cur_data);
      check("count", count, q.size());
      check("full", full, q.size() == DEPTH);
      check("empty", empty, q.size() == 0);
      check("rdata", rdata, exp_rdata);
      check("fifo_en", fifo_en, en);
   endtask

   task automatic new_op(input int p);
      rq[p] = 1'b1;
      ro[p] = ($urandom_range(0, 99) < pop_pct);
      rw[p] = WIDTH'($urandom);
   endtask

   task automatic drive();
      for (int p = 0; p < 2; p++) begin
         if (k == ack_edge && int'(cur_port) == p) begin
            if ($urandom_range(0, 1) == 1) new_op(p);
            else rq[p] = 1'b0;
         end else if (!rq[p] && $urandom_range(0, 2) == 0) begin
            new_op(p);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_reset_vals();
      rq = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      last = 1; exp_rdata = '0;
      ack_edge = -10; s_edge = -10;
      next_samp = k + 1;
      n_rst++;
   endtask

   initial begin
      // both ports push from reset: port 0 must win the first tie
      rq = 2'b11; ro = 2'b00; rw[0] = 8'h11; rw[1] = 8'h22;
      pop_pct = 50; en_low = 0; n_ack = 0; n_rst = 0;
      cur_port = 1'b0; cur_op = 1'b0; cur_rej = 1'b0; cur_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      k = 0;
      check_reset_vals();
      rst = 1'b0;
      next_samp = 1; s_edge = -10; ack_edge = -10; last = 1; exp_rdata = '0;
      q.delete();

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk);
         en_s = en;
         #1;
         if (en_s) begin
            k++;
            model_step();
         end
         compare();
         if (en_s) drive();
         if (cyc % 256 == 0) pop_pct = 20 + 30 * int'($urandom_range(0, 2));
         if (en_low > 0) begin
            en = 1'b0; en_low--;
         end else if (cyc > 20 && $urandom_range(0, 39) == 0) begin
            en = 1'b0; en_low = 2;
         end else begin
            en = ($urandom_range(0, 9) != 0);
         end
         if (cyc > 20 && !cur_rej && s_edge > 0 && (k == s_edge || k == s_edge + 1)
             && $urandom_range(0, 19) == 0)
            do_reset();
      end
      check("activity", n_ack > 200, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
